wb_sp_ram_arbiter: RTL
======================

WB_SP_RAM_ARBITER -- requirements
Module: wb_sp_ram_arbiter

Interface
REQ-001 Parameters SHALL be:
- Dw, 32, data width in bits.
- Aw, 10, word address width.
- SELw, Dw/8, byte-select width.
- CTIw, 3, cycle-type width.
- BTEw, 2, burst-type width.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock.
REQ-003 Port reset SHALL be an input, 1 bit, asynchronous active-high reset.
REQ-004 For each requester n in {0,1}, the mn_ inputs SHALL be:
- mn_dat_i, Dw.
- mn_sel_i, SELw.
- mn_addr_i, Aw.
- mn_cti_i, CTIw.
- mn_bte_i, BTEw.
- mn_stb_i, 1.
- mn_cyc_i, 1.
- mn_we_i, 1.
REQ-005 For each requester n, the outputs SHALL be mn_dat_o (Dw), mn_ack_o (1), mn_err_o (1) and mn_rty_o (1).
REQ-006 RAM-controller-side outputs SHALL be s_dat_o (Dw), s_sel_o (SELw), s_addr_o (Aw), s_cti_o (CTIw), s_bte_o (BTEw), s_stb_o (1), s_cyc_o (1) and s_we_o (1).
REQ-007 RAM-controller-side inputs SHALL be s_dat_i (Dw), s_ack_i (1), s_err_i (1) and s_rty_i (1).
REQ-008 Status outputs SHALL be:
- grant_o, 2 bits, one-hot current owner.
- busy_o, 1 bit, a requester owns the slave port.

Function
REQ-009 The FSM SHALL have the states IDLE, OWN0 and OWN1, with the state held in a register.
REQ-010 In IDLE, a request SHALL be mn_cyc_i=1, and the arbiter SHALL move to OWNn on the next clk edge.
REQ-011 If both requesters assert cyc in IDLE, the winner SHALL be the requester not served last, tracked by a 1-bit last_owner register (reset value 1, so requester 0 wins first).
REQ-012 In OWNn, all s_* outputs SHALL be combinationally driven from requester n's inputs.
REQ-013 In IDLE, s_stb_o, s_cyc_o and s_we_o SHALL be 0, and all other s_* outputs SHALL be 0.
REQ-014 In OWNn, mn_ack_o/err_o/rty_o SHALL equal s_ack_i/err_i/rty_i; the other requester's ack/err/rty SHALL be 0.
REQ-015 mn_dat_o SHALL equal s_dat_i for both requesters at all times.
REQ-016 Ownership SHALL be held while mn_cyc_i=1, so bursts (cti 3'b010) and multi-beat cycles are never split.
REQ-017 When the owner drops cyc in OWNn:
- if the other requester's cyc=1, go directly to OWN(other) next edge with no IDLE bubble;
- otherwise go to IDLE.
- last_owner SHALL be set to n in both cases.
REQ-018 A request SHALL be granted exactly 1 cycle after cyc rises while the port is idle.
REQ-019 A non-owner requester SHALL see ack/err/rty=0 and SHALL be stalled; no request queueing beyond cyc level SHALL exist.
REQ-020 A starvation counter SHALL count cycles in which the non-owner requests while the owner holds.
- It SHALL be 16 bits and saturating.
- It SHALL clear on each ownership change.
- Its value SHALL be exposed as wait_cnt_o (16-bit output).
REQ-021 If the owner's cyc falls and a new cyc rises from the same requester in the same cycle, the other requester (if requesting) SHALL win.
REQ-022 A simultaneous s_ack_i and owner cyc drop SHALL still route the ack to the old owner in that cycle.
REQ-023 grant_o SHALL be 2'b00 in IDLE, 2'b01 in OWN0 and 2'b10 in OWN1; busy_o SHALL equal |grant_o.

Reset
REQ-024 Reset assertion SHALL force, asynchronously:
- state IDLE, last_owner=1, wait_cnt_o=0;
- grant_o=0, busy_o=0;
- all s_* outputs 0 and all mn_ack/err/rty_o 0.
REQ-025 Reset asserted mid-burst SHALL abort ownership immediately; after release, arbitration SHALL restart from IDLE.

Structure
REQ-026 The state encodings (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the default widths SHALL live in a shared package, wb_arb_pkg.
REQ-027 Round-robin winner selection SHALL be a sub-module, wb_rr_grant2 (inputs req[1:0] and last; output one-hot gnt), which SHALL be purely combinational.
REQ-028 The block SHALL sit between two Wishbone masters and the existing Wishbone BRAM controller and single-port RAM wrapper, and SHALL require no change to either of those blocks.

Verification
REQ-029 Scenario: m0 single write (addr 0x005, data 0xDEADBEEF, sel 4'hF) with m1 idle -> grant_o=01 one cycle after m0_cyc_i rises; m0_ack_o pulses; m1_ack_o stays 0; a readback returns 0xDEADBEEF.
REQ-030 Scenario: m0 and m1 both assert cyc in the same cycle after reset -> m0 is granted first; when m0 drops cyc, m1 is granted on the next edge with no IDLE cycle; wait_cnt_o is nonzero before the switch.
REQ-031 Scenario: m1 issues a 4-beat incrementing burst (cti 010,010,010,111; addr 0x010 to 0x013) while m0 requests mid-burst -> all 4 acks go to m1 only; m0 is granted after m1 drops cyc.
REQ-032 Scenario: m0 drops cyc and reasserts it in the same cycle while m1 requests -> m1 wins.
REQ-033 Scenario: reset is asserted during a burst owned by m0 -> grant_o=00, s_cyc_o=0 and all acks 0 immediately; after release, m1 alone requests and is granted in 1 cycle.
REQ-034 Scenario: 65540 stall cycles on m1 while m0 holds cyc -> wait_cnt_o saturates at 0xFFFF and clears on the handover.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter in front of the
// single-port RAM controller: default bus widths, arbiter state encoding,
// and the starvation-counter width/ceiling.
package wb_arb_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned AW_DEF   = 10;
  localparam int unsigned CTIW_DEF = 3;
  localparam int unsigned BTEW_DEF = 2;
  localparam int unsigned WAITW    = 16;

  localparam logic [WAITW-1:0] WAIT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_rr_grant2.sv
// Two-way round-robin winner select, purely combinational.
//   req  : cyc levels of requester 1 (bit 1) and requester 0 (bit 0)
//   last : requester served most recently
//   gnt  : one-hot winner, 2'b00 when nobody requests
module wb_rr_grant2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On a tie the requester that was not served last wins.
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/wb_sp_ram_arbiter.sv
// Arbitrates two Wishbone masters (m0_*, m1_*) onto one slave port (s_*)
// that feeds the BRAM controller / single-port RAM wrapper unchanged.
//   clk, reset       : clock, asynchronous active-high reset
//   mN_*_i           : requester N cycle inputs (dat/sel/addr/cti/bte/stb/cyc/we)
//   mN_dat_o         : read data, s_dat_i broadcast to both requesters
//   mN_ack/err/rty_o : slave termination, routed to the owner only
//   s_*_o / s_*_i    : slave-side cycle out, termination/data in
//   grant_o, busy_o  : one-hot owner and "port owned" status
//   wait_cnt_o       : saturating count of cycles the non-owner has stalled
module wb_sp_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned Dw   = DW_DEF,
  parameter int unsigned Aw   = AW_DEF,
  parameter int unsigned SELw = Dw / 8,
  parameter int unsigned CTIw = CTIW_DEF,
  parameter int unsigned BTEw = BTEW_DEF
) (
  input  logic             clk,
  input  logic             reset,

  input  logic [Dw-1:0]    m0_dat_i,
  input  logic [SELw-1:0]  m0_sel_i,
  input  logic [Aw-1:0]    m0_addr_i,
  input  logic [CTIw-1:0]  m0_cti_i,
  input  logic [BTEw-1:0]  m0_bte_i,
  input  logic             m0_stb_i,
  input  logic             m0_cyc_i,
  input  logic             m0_we_i,
  output logic [Dw-1:0]    m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic             m0_rty_o,

  input  logic [Dw-1:0]    m1_dat_i,
  input  logic [SELw-1:0]  m1_sel_i,
  input  logic [Aw-1:0]    m1_addr_i,
  input  logic [CTIw-1:0]  m1_cti_i,
  input  logic [BTEw-1:0]  m1_bte_i,
  input  logic             m1_stb_i,
  input  logic             m1_cyc_i,
  input  logic             m1_we_i,
  output logic [Dw-1:0]    m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             m1_rty_o,

  output logic [Dw-1:0]    s_dat_o,
  output logic [SELw-1:0]  s_sel_o,
  output logic [Aw-1:0]    s_addr_o,
  output logic [CTIw-1:0]  s_cti_o,
  output logic [BTEw-1:0]  s_bte_o,
  output logic             s_stb_o,
  output logic             s_cyc_o,
  output logic             s_we_o,
  input  logic [Dw-1:0]    s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic             s_rty_i,

  output logic [1:0]       grant_o,
  output logic             busy_o,
  output logic [WAITW-1:0] wait_cnt_o
);

  arb_state_e       state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic [WAITW-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]       rr_gnt;
  logic             stall;

  wb_rr_grant2 u_rr (
    .req  ({m1_cyc_i, m0_cyc_i}),
    .last (last_owner_q),
    .gnt  (rr_gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    stall        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rr_gnt[0]) begin
          state_d = OWN0;
        end else if (rr_gnt[1]) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        stall = m0_cyc_i && m1_cyc_i;
        // A waiting peer takes over directly; a same-cycle re-request by
        // the old owner loses because ownership only follows the peer.
        if (!m0_cyc_i) begin
          last_owner_d = 1'b0;
          state_d      = m1_cyc_i ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        stall = m1_cyc_i && m0_cyc_i;
        if (!m1_cyc_i) begin
          last_owner_d = 1'b1;
          state_d      = m0_cyc_i ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (stall && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Slave-side mux and termination routing follow the registered owner, so
  // a termination arriving as the owner drops cyc still reaches that owner.
  always_comb begin
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_addr_o = '0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    s_we_o   = 1'b0;
    unique case (state_q)
      OWN0: begin
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_addr_o = m0_addr_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        s_stb_o  = m0_stb_i;
        s_cyc_o  = m0_cyc_i;
        s_we_o   = m0_we_i;
      end
      OWN1: begin
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_addr_o = m1_addr_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        s_stb_o  = m1_stb_i;
        s_cyc_o  = m1_cyc_i;
        s_we_o   = m1_we_i;
      end
      default: ;
    endcase
  end

  assign grant_o    = {state_q == OWN1, state_q == OWN0};
  assign busy_o     = |grant_o;
  assign wait_cnt_o = wait_cnt_q;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = grant_o[0] & s_ack_i;
  assign m0_err_o = grant_o[0] & s_err_i;
  assign m0_rty_o = grant_o[0] & s_rty_i;
  assign m1_ack_o = grant_o[1] & s_ack_i;
  assign m1_err_o = grant_o[1] & s_err_i;
  assign m1_rty_o = grant_o[1] & s_rty_i;

endmodule
